memory_page_reader: RTL

- Read-side engine for the paged BRAM Memory block.
- On a start pulse it latches one page index and that page's entry count (nent).
- It issues sequential reads through the Memory read port (addrb/enb) and absorbs the 2-cycle HIGH_PERFORMANCE read latency.
- It streams the entries downstream on a valid/ready interface with a last flag, then pulses done.

---
 rtl/memory_page_reader_pkg.sv | 34 +++
 rtl/memory_page_reader_stream_fifo.sv | 89 ++++++++
 rtl/memory_page_reader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_page_reader_pkg.sv
// -----------------------------------------------------------------------------
// memory_page_reader_pkg
// Shared constants for the paged BRAM Memory and its readers/writers:
// default page geometry, nent field width, read latency, the clogb2 helper
// and the reader FSM state type.
// -----------------------------------------------------------------------------
package memory_page_reader_pkg;

  localparam int DEF_RAM_WIDTH    = 18;
  localparam int DEF_RAM_DEPTH    = 1024;
  localparam int DEF_NPAGE        = 8;
  localparam int DEF_PAGE_DEPTH   = DEF_RAM_DEPTH / DEF_NPAGE;
  localparam int DEF_NENT_WIDTH   = 8;
  localparam int DEF_READ_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH   = 8;

  // ceil(log2(value)), never less than 1 so it is always a legal vector width
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/memory_page_reader_stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Synchronous FIFO with a registered output stage. The output register is
// refilled from storage, or directly from the write port when storage is
// empty, so a write into an empty FIFO is visible on rd_valid_o the next cycle.
// Total capacity is DEPTH storage entries plus the output register.
//
// Ports:
//   clk, rst_n     clock, async active-low reset (clears pointers and valid)
//   wr_en_i        write strobe (caller guarantees no overflow)
//   wr_data_i      write data
//   rd_ready_i     downstream accepts the output word
//   rd_data_o      registered output word
//   rd_valid_o     rd_data_o holds a valid word
//   count_o        words held (storage + output register)
// -----------------------------------------------------------------------------
module stream_fifo
  import memory_page_reader_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  input  logic                          rd_ready_i,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic                          rd_valid_o,
  output logic [clogb2(DEPTH+2)-1:0]    count_o
);

  localparam int PTR_W = clogb2(DEPTH);
  localparam int CNT_W = clogb2(DEPTH + 2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] scount_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  logic pop, load, st_empty, st_rd, bypass, st_wr;

  assign pop      = out_valid_q && rd_ready_i;
  assign load     = !out_valid_q || pop;
  assign st_empty = (scount_q == '0);
  assign st_rd    = load && !st_empty;
  // empty storage and a free output slot: the write goes straight to the output
  assign bypass   = load && st_empty && wr_en_i;
  assign st_wr    = wr_en_i && !bypass;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      scount_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (st_wr) wptr_q <= ptr_next(wptr_q);
      if (st_rd) rptr_q <= ptr_next(rptr_q);
      scount_q <= scount_q + CNT_W'(st_wr) - CNT_W'(st_rd);
      if (load) begin
        if (st_rd) begin
          out_data_q  <= mem_q[rptr_q];
          out_valid_q <= 1'b1;
        end else if (wr_en_i) begin
          out_data_q  <= wr_data_i;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (st_wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o  = out_data_q;
  assign rd_valid_o = out_valid_q;
  assign count_o    = scount_q + CNT_W'(out_valid_q);

endmodule

// File: rtl/memory_page_reader.sv
// -----------------------------------------------------------------------------
// memory_page_reader
// Reads one page of the paged BRAM Memory and streams its entries out on a
// valid/ready interface, flagging the last entry and pulsing done afterwards.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start; latches page and clamped entry count
//   ST_READ   | issuing reads while credit is available
//   ST_DRAIN  | all reads issued; waiting for the last entry to be accepted
//   ST_FINISH | done pulse, busy still high; returns to idle
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, page_i     request and page index
//   nent_flat         per-page entry counts, page k at [k*NENT_WIDTH +: NENT_WIDTH]
//   addrb, enb        Memory read address / enable
//   regceb, rstb      Memory output register controls (constant 1 / 0)
//   doutb             Memory read data, READ_LATENCY cycles after enb
//   dout_data/valid/ready/last  output stream
//   busy, done        status
// -----------------------------------------------------------------------------
module memory_page_reader
  import memory_page_reader_pkg::*;
#(
  parameter int RAM_WIDTH    = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter int NPAGE        = DEF_NPAGE,
  parameter int PAGE_DEPTH   = RAM_DEPTH / NPAGE,
  parameter int NENT_WIDTH   = DEF_NENT_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [clogb2(NPAGE)-1:0]      page_i,
  input  logic [NPAGE*NENT_WIDTH-1:0]   nent_flat,
  output logic [clogb2(RAM_DEPTH)-1:0]  addrb,
  output logic                          enb,
  output logic                          regceb,
  output logic                          rstb,
  input  logic [RAM_WIDTH-1:0]          doutb,
  output logic [RAM_WIDTH-1:0]          dout_data,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          busy,
  output logic                          done
);

  localparam int ADDR_W     = clogb2(RAM_DEPTH);
  localparam int PAGE_W     = clogb2(NPAGE);
  localparam int CNT_W      = clogb2(PAGE_DEPTH + 1);
  localparam int FIFO_CNT_W = clogb2(FIFO_DEPTH + 2);
  localparam int OUT_W      = clogb2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  state_e                  state_q;
  logic [PAGE_W-1:0]       page_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        idx_q;
  logic [ADDR_W-1:0]       addrb_q;
  logic                    enb_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    done_q;
  logic [READ_LATENCY-1:0] pipe_v_q;
  logic [READ_LATENCY-1:0] pipe_l_q;

  logic [NENT_WIDTH-1:0]   nent_sel;
  logic [CNT_W-1:0]        clamp_d;
  logic [ADDR_W-1:0]       start_base_d;
  logic [ADDR_W-1:0]       issue_addr_d;
  logic                    idx_last;
  logic                    xfer;
  logic [OUT_W-1:0]        outstanding_d;
  logic                    can_issue;
  logic                    cap_valid;
  logic                    cap_last;
  logic [FIFO_CNT_W-1:0]   fifo_count;

  assign nent_sel     = nent_flat[int'(page_i) * NENT_WIDTH +: NENT_WIDTH];
  assign clamp_d      = (int'(nent_sel) > PAGE_DEPTH) ? CNT_W'(PAGE_DEPTH) : CNT_W'(nent_sel);
  assign start_base_d = ADDR_W'(int'(page_i) * PAGE_DEPTH);
  assign issue_addr_d = ADDR_W'(int'(page_q) * PAGE_DEPTH + int'(idx_q));
  assign idx_last     = (idx_q == cnt_q - CNT_W'(1));
  assign xfer         = dout_valid && dout_ready;

  // Reads that will still be held after this edge: the one on the port, the
  // latency pipeline and the FIFO, less the word leaving now. A new read may
  // be issued only if that leaves room for it in the FIFO.
  always_comb begin
    outstanding_d = OUT_W'(enb_q) + OUT_W'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding_d = outstanding_d + OUT_W'(pipe_v_q[i]);
    end
    outstanding_d = outstanding_d - OUT_W'(xfer);
    can_issue     = (outstanding_d < OUT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addrb_q <= '0;
      enb_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      enb_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            page_q <= page_i;
            cnt_q  <= clamp_d;
            busy_q <= 1'b1;
            if (clamp_d == '0) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              // the pipeline and FIFO are empty in idle, so the first read
              // needs no credit check
              state_q <= ST_READ;
              enb_q   <= 1'b1;
              addrb_q <= start_base_d;
              last_q  <= (clamp_d == CNT_W'(1));
              idx_q   <= CNT_W'(1);
            end
          end
        end
        ST_READ: begin
          if (idx_q == cnt_q) begin
            state_q <= ST_DRAIN;
          end else if (can_issue) begin
            enb_q   <= 1'b1;
            addrb_q <= issue_addr_d;
            last_q  <= idx_last;
            idx_q   <= idx_q + CNT_W'(1);
            if (idx_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (xfer && dout_last) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // enb and its last tag delayed by the Memory read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q <= '0;
      pipe_l_q <= '0;
    end else begin
      pipe_v_q[0] <= enb_q;
      pipe_l_q[0] <= enb_q && last_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_l_q[i] <= pipe_l_q[i-1];
      end
    end
  end

  assign cap_valid = pipe_v_q[READ_LATENCY-1];
  assign cap_last  = pipe_l_q[READ_LATENCY-1];

  stream_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (cap_valid),
    .wr_data_i  ({cap_last, doutb}),
    .rd_ready_i (dout_ready),
    .rd_data_o  ({dout_last, dout_data}),
    .rd_valid_o (dout_valid),
    .count_o    (fifo_count)
  );

  assign addrb  = addrb_q;
  assign enb    = enb_q;
  assign regceb = 1'b1;
  assign rstb   = 1'b0;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
